harris_window_feeder: RTL

- Upstream producer for the Harris score stage. Accepts a raster-order stream of per-pixel signed gradient pairs (Gx, Gy).
- Buffers the three previous image rows and presents every fully populated 4x4 window of Gx and Gy, with a valid/ready handshake and the window's top-left coordinate.
- Sits between the gradient (Sobel) stage and harris_score. Its window buses map one-to-one onto the score block's Gx/Gy inputs.

---
 rtl/harris_pkg.sv | 18 +
 rtl/harris_window_feeder_if.sv | 28 ++
 rtl/harris_line_buffer.sv | 26 ++
 rtl/harris_window_feeder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/harris_pkg.sv
// Shared definitions for the Harris corner pipeline: sample width, window size
// and the flat bit layout of a 4x4 window bus.
package harris_pkg;

    localparam int GW  = 16;
    localparam int WIN = 4;

    typedef struct packed {
        logic signed [GW-1:0] gx;
        logic signed [GW-1:0] gy;
    } grad_pair_t;

    // Element (r,c) of a window bus lives at bits [GW*idx(r,c) +: GW].
    function automatic int idx(input int r, input int c);
        return WIN * r + c;
    endfunction

endpackage

// File: rtl/harris_window_feeder_if.sv
// Gradient stream in, 4x4 window stream out; master drives pixels and
// consumes windows, slave is the feeder itself.
interface harris_window_feeder_if #(
    parameter int GW = 16,
    parameter int CW = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [GW-1:0]      gx_in;
    logic [GW-1:0]      gy_in;
    logic               win_valid;
    logic               win_ready;
    logic [16*GW-1:0]   gx_win;
    logic [16*GW-1:0]   gy_win;
    logic [CW-1:0]      win_x;
    logic [CW-1:0]      win_y;
    logic               frame_done;

    modport master (
        output in_valid, gx_in, gy_in, win_ready,
        input  in_ready, win_valid, gx_win, gy_win, win_x, win_y, frame_done
    );

    modport slave (
        input  in_valid, gx_in, gy_in, win_ready,
        output in_ready, win_valid, gx_win, gy_win, win_x, win_y, frame_done
    );
endinterface

// File: rtl/harris_line_buffer.sv
// One image row of storage. The read port is combinational so the caller sees
// the old entry at addr in the same cycle the new one is written.
module harris_line_buffer #(
    parameter int DEPTH = 64,
    parameter int DW    = 32,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    assign rdata = mem_r[addr];

    // Row memory write; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

endmodule

// File: rtl/harris_window_feeder.sv
// Turns a raster stream of (Gx,Gy) pairs into a stream of fully populated 4x4
// windows using three chained row buffers and a 4x4 shift register.
module harris_window_feeder #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 48,
    parameter int GW    = 16,
    parameter int CW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    harris_window_feeder_if.slave  bus
);
    import harris_pkg::*;

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
    localparam logic [CW-1:0] EDGE     = CW'(WIN - 1);

    logic                      in_ready_s;
    logic                      xfer_s;
    logic                      emit_s;
    logic [CW-1:0]             col_r, col_s;
    logic [CW-1:0]             row_r, row_s;
    logic                      win_valid_r, win_valid_s;
    logic [CW-1:0]             win_x_r, win_x_s;
    logic [CW-1:0]             win_y_r, win_y_s;
    logic                      frame_done_r, frame_done_s;
    logic [2*GW-1:0]           in_pair_s;
    logic [2*GW-1:0]           rd0_s, rd1_s, rd2_s;
    logic [WIN-1:0][GW-1:0]    col_gx_s, col_gy_s;
    logic [WIN*WIN*GW-1:0]     gx_win_r, gy_win_r;

    // A held window blocks the stream; there is only one output stage.
    assign in_ready_s = !win_valid_r || bus.win_ready;
    assign xfer_s     = bus.in_valid && in_ready_s;
    // Left-edge columns would mix in the tail of the previous row.
    assign emit_s     = xfer_s && (row_r >= EDGE) && (col_r >= EDGE);
    assign in_pair_s  = {bus.gx_in, bus.gy_in};

    // rd0/rd1/rd2 are rows row-1/row-2/row-3 at the current column.
    harris_line_buffer #(.DEPTH(IMG_W), .DW(2*GW)) u_lb0 (
        .clk   (clk),
        .we    (xfer_s),
        .addr  (col_r[AW-1:0]),
        .wdata (in_pair_s),
        .rdata (rd0_s)
    );

    harris_line_buffer #(.DEPTH(IMG_W), .DW(2*GW)) u_lb1 (
        .clk   (clk),
        .we    (xfer_s),
        .addr  (col_r[AW-1:0]),
        .wdata (rd0_s),
        .rdata (rd1_s)
    );

    harris_line_buffer #(.DEPTH(IMG_W), .DW(2*GW)) u_lb2 (
        .clk   (clk),
        .we    (xfer_s),
        .addr  (col_r[AW-1:0]),
        .wdata (rd1_s),
        .rdata (rd2_s)
    );

    // Incoming column of the window, oldest row first.
    always_comb begin
        col_gx_s    = '0;
        col_gy_s    = '0;
        col_gx_s[0] = rd2_s[2*GW-1 -: GW];
        col_gy_s[0] = rd2_s[GW-1:0];
        col_gx_s[1] = rd1_s[2*GW-1 -: GW];
        col_gy_s[1] = rd1_s[GW-1:0];
        col_gx_s[2] = rd0_s[2*GW-1 -: GW];
        col_gy_s[2] = rd0_s[GW-1:0];
        col_gx_s[3] = bus.gx_in;
        col_gy_s[3] = bus.gy_in;
    end

    // Window shift register: every row moves left, new column enters at c=3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx_win_r <= '0;
            gy_win_r <= '0;
        end else if (xfer_s) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    gx_win_r[GW*idx(r, c) +: GW] <= gx_win_r[GW*idx(r, c + 1) +: GW];
                    gy_win_r[GW*idx(r, c) +: GW] <= gy_win_r[GW*idx(r, c + 1) +: GW];
                end
                gx_win_r[GW*idx(r, WIN - 1) +: GW] <= col_gx_s[r];
                gy_win_r[GW*idx(r, WIN - 1) +: GW] <= col_gy_s[r];
            end
        end else begin
            gx_win_r <= gx_win_r;
            gy_win_r <= gy_win_r;
        end
    end

    // Raster position and end-of-frame detection.
    always_comb begin
        col_s        = col_r;
        row_s        = row_r;
        frame_done_s = 1'b0;
        if (xfer_s) begin
            if (col_r == LAST_COL) begin
                col_s = '0;
                if (row_r == LAST_ROW) begin
                    row_s        = '0;
                    frame_done_s = 1'b1;
                end else begin
                    row_s = row_r + CW'(1);
                end
            end else begin
                col_s = col_r + CW'(1);
            end
        end else begin
            col_s = col_r;
        end
    end

    // Output-stage next state: load on emit, retire on accept, else hold.
    always_comb begin
        win_valid_s = win_valid_r;
        win_x_s     = win_x_r;
        win_y_s     = win_y_r;
        if (emit_s) begin
            win_valid_s = 1'b1;
            win_x_s     = col_r - EDGE;
            win_y_s     = row_r - EDGE;
        end else if (bus.win_ready) begin
            win_valid_s = 1'b0;
        end else begin
            win_valid_s = win_valid_r;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r        <= '0;
            row_r        <= '0;
            win_valid_r  <= 1'b0;
            win_x_r      <= '0;
            win_y_r      <= '0;
            frame_done_r <= 1'b0;
        end else begin
            col_r        <= col_s;
            row_r        <= row_s;
            win_valid_r  <= win_valid_s;
            win_x_r      <= win_x_s;
            win_y_r      <= win_y_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.win_valid  = win_valid_r;
    assign bus.gx_win     = gx_win_r;
    assign bus.gy_win     = gy_win_r;
    assign bus.win_x      = win_x_r;
    assign bus.win_y      = win_y_r;
    assign bus.frame_done = frame_done_r;

endmodule
